// File: rtl/instr_mem_responder.sv
// Instruction-memory responder for the CPU fetch port.
// A fetch request latches PC, stalls the CPU for READ_LATENCY+1 cycles
// (busywait high), then presents the registered instruction word and a
// fault flag for one RESP cycle. A separate load port writes program words
// while the responder is idle and no fetch is being requested.
//
// Handshake: the CPU holds read high until busywait drops; the cycle in
// which busywait is low after having been high is the response cycle, and
// instruction/fault are valid from then on until the next response or reset.
// A load is accepted only in IDLE with read low; load_ack pulses for the one
// cycle after the accepting edge.
module instr_mem_responder #(
  parameter int          ADDR_BITS    = 10,
  parameter int          READ_LATENCY = 4,
  parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          PC,
  input  logic                 read,
  output logic [31:0]          instruction,
  output logic                 busywait,
  output logic                 fault,
  input  logic                 load_en,
  input  logic [ADDR_BITS-3:0] load_addr,
  input  logic [31:0]          load_data,
  output logic                 load_ack,
  output logic [1:0]           dbg_state
);

  localparam int DEPTH = 2 ** (ADDR_BITS - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        fault_q, fault_d;
  logic        load_ack_q, load_ack_d;
  logic        busy_raw;
  logic        mem_we;
  logic        addr_fault;

  logic [31:0] mem [DEPTH];

  // A fetch faults when the latched address is misaligned or beyond the array.
  assign addr_fault = (addr_q[1:0] != 2'b00) || (addr_q[31:ADDR_BITS] != '0);

  // Next-state and output decode; fetch takes priority over load in IDLE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    fault_d    = fault_q;
    load_ack_d = 1'b0;
    mem_we     = 1'b0;
    busy_raw   = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_raw = read;
        if (read) begin
          addr_d  = PC;
          cnt_d   = 4'(READ_LATENCY);
          state_d = S_BUSY;
        end else if (load_en) begin
          mem_we     = 1'b1;
          load_ack_d = 1'b1;
        end
      end
      S_BUSY: begin
        busy_raw = 1'b1;
        cnt_d    = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          if (addr_fault) begin
            instr_d = NOP_WORD;
            fault_d = 1'b1;
          end else begin
            instr_d = mem[addr_q[ADDR_BITS-1:2]];
            fault_d = 1'b0;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and response registers; reset aborts any fetch in flight.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'h0;
      instr_q    <= 32'h0;
      fault_q    <= 1'b0;
      load_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      fault_q    <= fault_d;
      load_ack_q <= load_ack_d;
    end
  end

  // Program array write; contents survive reset.
  always_ff @(posedge CLK) begin
    if (mem_we && RESET) begin
      mem[load_addr] <= load_data;
    end
  end

  assign busywait    = RESET & busy_raw;
  assign instruction = instr_q;
  assign fault       = fault_q;
  assign load_ack    = load_ack_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Instruction-memory responder: the fetch side that answers the CPU's PC/Instruction interface.
- Accepts a word-aligned byte address on a read request and holds busywait high for a fixed multi-cycle latency.
- Then returns the 32-bit instruction word for one valid cycle.
- A separate load port writes program words into the array before or between fetches.

Parameters:
ADDR_BITS, 10, byte-address width of the array; depth = 2**(ADDR_BITS-2) 32-bit words
READ_LATENCY, 4, number of BUSY cycles per fetch; legal range 1..15
NOP_WORD, 32'h0000_0000, instruction returned on a faulting fetch

Ports:
CLK  in  1  clock, all state updates on rising edge
RESET  in  1  asynchronous, active-low reset (0 = in reset)
PC  in  32  byte address of requested instruction, sampled at request acceptance
read  in  1  fetch request, level-held by CPU until busywait drops
instruction  out  32  fetched word, registered
busywait  out  1  stall indication to CPU
fault  out  1  last completed fetch was misaligned or out of range
load_en  in  1  program-load write strobe
load_addr  in  ADDR_BITS-2  word index for load write
load_data  in  32  word to write
load_ack  out  1  one-cycle pulse: load write accepted

Behaviour:
- Reset (RESET=0, async):
  - state=IDLE, instruction=32'h0, fault=0, load_ack=0, counter=0.
  - busywait forced 0 while RESET=0 regardless of read.
  - Memory array is not cleared.
- States: IDLE, BUSY, RESP.
- IDLE:
  - busywait = read (combinational).
  - On posedge with read=1: latch PC into addr_q, counter=READ_LATENCY, go BUSY.
- BUSY:
  - busywait=1; counter decrements each posedge.
  - On the posedge where counter==1, go RESP and register instruction/fault.
  - PC and read changes during BUSY are ignored.
- RESP:
  - busywait=0; instruction and fault valid; next posedge always goes IDLE.
  - A read still high in the following IDLE cycle starts a new fetch; this is back-to-back fetching.
- Timing: read rising in cycle 0 gives busywait=1 for cycles 0..READ_LATENCY; cycle READ_LATENCY+1 has busywait=0 with valid instruction. Fetch period = READ_LATENCY+2 cycles.
- instruction and fault hold their values until the next RESP load or reset.
- Fault condition: addr_q[1:0]!=0 OR addr_q[31:ADDR_BITS]!=0.
  - On fault: instruction=NOP_WORD, fault=1; same latency as a normal fetch.
  - Otherwise: instruction=mem[addr_q[ADDR_BITS-1:2]], fault=0.
- Load port:
  - Write is accepted on posedge only when state==IDLE and read==0 and load_en==1.
  - On acceptance: mem[load_addr]=load_data, load_ack=1 for that following cycle, else load_ack=0.
  - load_en during BUSY/RESP, or with read=1, is dropped silently with no ack. A fetch has priority over a load in the same IDLE cycle.
- Reset asserted mid-fetch: abort immediately to IDLE with reset values. No instruction is delivered. Deasserting reset with read=1 starts a fresh fetch.
- Write-then-read of the same word: a load accepted at edge N is visible to a fetch accepted at edge N+1 or later.

Test Plan:
- Reset then load words 0x00000404 at index 0 and 0x01020304 at index 1 -> load_ack one cycle each; fetch PC=0 then PC=4 with READ_LATENCY=4 -> busywait high 5 cycles each, then instruction=0x00000404 and 0x01020304, fault=0.
- Back-to-back: read held high, PC advanced to 4 on the RESP cycle -> second fetch starts in the next IDLE cycle; total 12 cycles for two fetches.
- PC=0x00000002 (misaligned) and PC=0x00000400 (out of range, ADDR_BITS=10) -> after 5 busy cycles instruction=0x00000000, fault=1; next good fetch clears fault.
- load_en=1 during BUSY and together with read=1 in IDLE -> no load_ack; array unchanged on subsequent fetch of that index.
- Assert RESET=0 in the 3rd BUSY cycle -> busywait=0, instruction=0 immediately (asynchronous); release with read=1, PC=4 -> full 5-cycle fetch returns mem[1].
- PC changed to 8 during BUSY of a PC=4 fetch -> returned word is mem[1], not mem[2].
